// File: rtl/fir_mon_pkg.sv
// Shared types and helpers for the FIR tone monitor: FSM encoding, default widths and
// a saturating absolute value.
package fir_mon_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StLocked
  } mon_state_e;

  localparam int unsigned DefDataW = 31;
  localparam int unsigned DefCntW  = 16;
  localparam int unsigned AbsMaxW  = 64;

  // x holds a sign-extended w-bit value; the most negative w-bit input clamps to 2^(w-1)-1.
  function automatic logic [AbsMaxW-1:0] abs_sat(input logic signed [AbsMaxW-1:0] x,
                                                 input int unsigned w);
    logic [AbsMaxW-1:0] lim;
    lim = (AbsMaxW'(1) << (w - 1)) - AbsMaxW'(1);
    if (!x[AbsMaxW-1]) return x;
    if ($unsigned(-x) > lim) return lim;
    return -x;
  endfunction

endpackage

// File: rtl/fir_hyst_slicer.sv
// Registered hysteresis slicer: tracks tone polarity, flags rising crossings and
// produces the saturated magnitude of each accepted sample.
module fir_hyst_slicer
  import fir_mon_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned HYST   = 1024
) (
  input  logic              clk_i,
  input  logic              srst_ni,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic              rise_o,
  output logic [DATA_W-2:0] mag_o
);

  localparam logic signed [DATA_W-1:0] HystPos = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] HystNeg = -HystPos;

  logic signed [DATA_W-1:0] x;
  logic                     pos_d, pos_q;
  logic                     rise_q, valid_q;
  logic [DATA_W-2:0]        mag_d, mag_q;

  assign x = $signed(data_i);

  always_comb begin
    pos_d = pos_q;
    if (x > HystPos) begin
      pos_d = 1'b1;
    end else if (x < HystNeg) begin
      pos_d = 1'b0;
    end
    mag_d = (DATA_W-1)'(abs_sat(AbsMaxW'(x), DATA_W));
  end

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      pos_q   <= 1'b0;
      rise_q  <= 1'b0;
      valid_q <= 1'b0;
      mag_q   <= '0;
    end else begin
      valid_q <= valid_i;
      rise_q  <= valid_i & ~pos_q & pos_d;
      if (valid_i) begin
        pos_q <= pos_d;
        mag_q <= mag_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign rise_o  = rise_q;
  assign mag_o   = mag_q;

endmodule

// File: rtl/fir_tone_monitor.sv
// Measures the period and peak of the filtered difference tone and declares lock after a
// run of in-range periods; sign_led mirrors the lock flag one cycle later.
module fir_tone_monitor
  import fir_mon_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned HYST       = 1024,
  parameter int unsigned PERIOD_MIN = 40,
  parameter int unsigned PERIOD_MAX = 60,
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              fir_valid_i,
  input  logic [DATA_W-1:0] fir_data_i,
  output logic [CNT_W-1:0]  period_o,
  output logic              period_valid_o,
  output logic [DATA_W-2:0] peak_o,
  output logic              tone_lock_o,
  output logic              sign_led
);

  localparam int unsigned      GoodW    = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PminC    = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] PmaxC    = CNT_W'(PERIOD_MAX);
  localparam logic [GoodW-1:0] LockC    = GoodW'(LOCK_CNT);

  logic              s_valid, s_rise;
  logic [DATA_W-2:0] s_mag;

  fir_hyst_slicer #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_slicer (
    .clk_i   (sclk),
    .srst_ni (s_rst_n),
    .valid_i (fir_valid_i),
    .data_i  (fir_data_i),
    .valid_o (s_valid),
    .rise_o  (s_rise),
    .mag_o   (s_mag)
  );

  mon_state_e        state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q, period_d, period_q, meas;
  logic [DATA_W-2:0] run_d, run_q, peak_d, peak_q;
  logic [GoodW-1:0]  good_d, good_q;
  logic              pv_d, pv_q, lock_q, led_q, in_range;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    period_d = period_q;
    peak_d   = peak_q;
    good_d   = good_q;
    pv_d     = 1'b0;
    meas     = cnt_q + CNT_W'(1);
    in_range = (meas >= PminC) && (meas <= PmaxC);
    if (s_valid) begin
      if (s_rise) begin
        // The crossing sample opens the next period's count and peak run.
        cnt_d = '0;
        run_d = s_mag;
        case (state_q)
          StIdle: state_d = StMeasure;
          StMeasure, StLocked: begin
            period_d = meas;
            peak_d   = run_q;
            pv_d     = 1'b1;
            if (!in_range) begin
              good_d  = '0;
              state_d = StMeasure;
            end else if (state_q == StMeasure) begin
              good_d = good_q + GoodW'(1);
              if (good_d == LockC) state_d = StLocked;
            end
          end
          default: state_d = StIdle;
        endcase
      end else begin
        if (cnt_q != TimeoutC) cnt_d = cnt_q + CNT_W'(1);
        if (s_mag > run_q) run_d = s_mag;
        if ((cnt_q != TimeoutC) && (cnt_d == TimeoutC)) begin
          state_d = StIdle;
          good_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      run_q    <= '0;
      period_q <= '0;
      peak_q   <= '0;
      good_q   <= '0;
      pv_q     <= 1'b0;
      lock_q   <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      period_q <= period_d;
      peak_q   <= peak_d;
      good_q   <= good_d;
      pv_q     <= pv_d;
      lock_q   <= (state_d == StLocked);
      led_q    <= lock_q;
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = pv_q;
  assign peak_o         = peak_q;
  assign tone_lock_o    = lock_q;
  assign sign_led       = led_q;

endmodule

// File: tb/tb_fir_tone_monitor.sv
// Directed bench for fir_tone_monitor: square tones, valid gaps, unlock/relock,
// range edges, timeout, saturated peak and mid-run reset.
module tb_fir_tone_monitor;

  localparam int unsigned DataW = 31;
  localparam int unsigned CntW  = 16;

  logic             sclk = 1'b0;
  logic             s_rst_n;
  logic             fir_valid_i;
  logic [DataW-1:0] fir_data_i;
  logic [CntW-1:0]  period_o;
  logic             period_valid_o;
  logic [DataW-2:0] peak_o;
  logic             tone_lock_o;
  logic             sign_led;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int mon_bad  = 0;
  int base_p, base_bad;
  logic [CntW-1:0]  exp_period;
  logic [DataW-2:0] exp_peak;

  always #5 sclk = ~sclk;

  fir_tone_monitor dut (
    .sclk           (sclk),
    .s_rst_n        (s_rst_n),
    .fir_valid_i    (fir_valid_i),
    .fir_data_i     (fir_data_i),
    .period_o       (period_o),
    .period_valid_o (period_valid_o),
    .peak_o         (peak_o),
    .tone_lock_o    (tone_lock_o),
    .sign_led       (sign_led)
  );

  // Every reported period/peak must match what the stimulus currently expects.
  always @(negedge sclk) begin
    if (period_valid_o === 1'b1) begin
      pulses = pulses + 1;
      if (period_o !== exp_period || peak_o !== exp_peak) mon_bad = mon_bad + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [DataW-1:0] d, input int gap);
    fir_valid_i = 1'b1;
    fir_data_i  = d;
    @(negedge sclk);
    for (int i = 0; i < gap; i++) begin
      fir_valid_i = 1'b0;
      @(negedge sclk);
    end
  endtask

  task automatic idle(input int n);
    fir_valid_i = 1'b0;
    for (int i = 0; i < n; i++) @(negedge sclk);
  endtask

  // One tone period; rep is the period its leading crossing is expected to report.
  task automatic tone_period(input int len, input int gap, input int rep, input bit use_min);
    exp_period = CntW'(rep);
    exp_peak   = (DataW-1)'(2000);
    for (int i = 0; i < len - len / 2; i++) send(DataW'(2000), gap);
    for (int i = 0; i < len / 2; i++) begin
      if (use_min && i == 0) send(DataW'(32'h4000_0000), gap);
      else send(DataW'(-2000), gap);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_period"}, 64'(period_o), 64'd0);
    check_eq({tag, "_pv"}, 64'(period_valid_o), 64'd0);
    check_eq({tag, "_peak"}, 64'(peak_o), 64'd0);
    check_eq({tag, "_lock"}, 64'(tone_lock_o), 64'd0);
    check_eq({tag, "_led"}, 64'(sign_led), 64'd0);
  endtask

  initial begin
    s_rst_n     = 1'b0;
    fir_valid_i = 1'b0;
    fir_data_i  = '0;
    exp_period  = CntW'(50);
    exp_peak    = (DataW-1)'(2000);

    // Reset with random traffic
    for (int i = 0; i < 4; i++) begin
      fir_valid_i = 1'($urandom_range(0, 1));
      fir_data_i  = DataW'($urandom);
      @(negedge sclk);
      check_zero("reset");
    end
    check_eq("reset_pulses", 64'(pulses), 64'd0);
    s_rst_n = 1'b1;
    idle(2);

    // Continuous square tone, lock after the 9th rising crossing
    base_p   = pulses;
    base_bad = mon_bad;
    for (int p = 0; p < 8; p++) tone_period(50, 0, 50, 1'b0);
    idle(2);
    check_eq("t2_pulses8", 64'(pulses - base_p), 64'd7);
    check_eq("t2_nolock8", 64'(tone_lock_o), 64'd0);
    exp_period = CntW'(50);
    send(DataW'(2000), 0);
    check_eq("t2_lock_t0", 64'(tone_lock_o), 64'd0);
    send(DataW'(2000), 0);
    check_eq("t2_lock_t1", 64'(tone_lock_o), 64'd1);
    check_eq("t2_led_t1", 64'(sign_led), 64'd0);
    check_eq("t2_pv_t1", 64'(period_valid_o), 64'd1);
    check_eq("t2_period_t1", 64'(period_o), 64'd50);
    send(DataW'(2000), 0);
    check_eq("t2_led_t2", 64'(sign_led), 64'd1);
    check_eq("t2_pv_t2", 64'(period_valid_o), 64'd0);
    for (int i = 0; i < 22; i++) send(DataW'(2000), 0);
    for (int i = 0; i < 25; i++) send(DataW'(-2000), 0);
    idle(2);
    check_eq("t2_pulses", 64'(pulses - base_p), 64'd8);
    check_eq("t2_bad", 64'(mon_bad - base_bad), 64'd0);

    // Valid every third cycle
    s_rst_n = 1'b0;
    @(negedge sclk);
    s_rst_n = 1'b1;
    check_eq("t3_rst_lock", 64'(tone_lock_o), 64'd0);
    check_eq("t3_rst_led", 64'(sign_led), 64'd0);
    base_p   = pulses;
    base_bad = mon_bad;
    for (int p = 0; p < 8; p++) tone_period(50, 2, 50, 1'b0);
    check_eq("t3_nolock8", 64'(tone_lock_o), 64'd0);
    tone_period(50, 2, 50, 1'b0);
    check_eq("t3_lock", 64'(tone_lock_o), 64'd1);
    check_eq("t3_period", 64'(period_o), 64'd50);
    check_eq("t3_pulses", 64'(pulses - base_p), 64'd8);
    check_eq("t3_bad", 64'(mon_bad - base_bad), 64'd0);

    // Short period breaks lock, then 8 good periods relock
    base_bad = mon_bad;
    tone_period(30, 0, 50, 1'b0);
    check_eq("t4_lock_30", 64'(tone_lock_o), 64'd1);
    tone_period(50, 0, 30, 1'b0);
    check_eq("t4_period30", 64'(period_o), 64'd30);
    check_eq("t4_unlock", 64'(tone_lock_o), 64'd0);
    for (int p = 0; p < 7; p++) tone_period(50, 0, 50, 1'b0);
    check_eq("t4_nolock7", 64'(tone_lock_o), 64'd0);
    tone_period(50, 0, 50, 1'b0);
    check_eq("t4_relock", 64'(tone_lock_o), 64'd1);

    // Range boundaries 40 and 60 are accepted, 61 is not
    tone_period(40, 0, 50, 1'b0);
    tone_period(60, 0, 40, 1'b0);
    check_eq("t4_period40", 64'(period_o), 64'd40);
    tone_period(61, 0, 60, 1'b0);
    check_eq("t4_period60", 64'(period_o), 64'd60);
    check_eq("t4_lock_edges", 64'(tone_lock_o), 64'd1);
    tone_period(50, 0, 61, 1'b0);
    check_eq("t4_period61", 64'(period_o), 64'd61);
    check_eq("t4_unlock61", 64'(tone_lock_o), 64'd0);
    for (int p = 0; p < 8; p++) tone_period(50, 0, 50, 1'b0);
    check_eq("t4_relock2", 64'(tone_lock_o), 64'd1);
    check_eq("t4_bad", 64'(mon_bad - base_bad), 64'd0);

    // In-hysteresis wobble until timeout
    base_p = pulses;
    for (int i = 0; i < 900; i++) send((i % 2 == 0) ? DataW'(500) : DataW'(-500), 0);
    check_eq("t5_still_locked", 64'(tone_lock_o), 64'd1);
    for (int i = 0; i < 200; i++) send((i % 2 == 0) ? DataW'(500) : DataW'(-500), 0);
    idle(2);
    check_eq("t5_timeout_lock", 64'(tone_lock_o), 64'd0);
    check_eq("t5_timeout_led", 64'(sign_led), 64'd0);
    check_eq("t5_period_hold", 64'(period_o), 64'd50);
    check_eq("t5_no_pulses", 64'(pulses - base_p), 64'd0);

    // Most negative sample saturates peak; then reset mid-period
    base_bad = mon_bad;
    tone_period(50, 0, 50, 1'b1);
    check_eq("t6_idle_no_report", 64'(pulses - base_p), 64'd0);
    exp_period = CntW'(50);
    exp_peak   = (DataW-1)'(31'h3FFF_FFFF);
    for (int i = 0; i < 10; i++) send(DataW'(2000), 0);
    check_eq("t6_peak_sat", 64'(peak_o), 64'h3FFF_FFFF);
    check_eq("t6_period", 64'(period_o), 64'd50);
    check_eq("t6_pulses", 64'(pulses - base_p), 64'd1);
    check_eq("t6_bad", 64'(mon_bad - base_bad), 64'd0);
    s_rst_n     = 1'b0;
    fir_valid_i = 1'b1;
    fir_data_i  = DataW'(2000);
    @(negedge sclk);
    check_zero("t6_midrst");
    s_rst_n     = 1'b1;
    fir_valid_i = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
